// File: rtl/cla_pkg.sv
// Shared constants, the group P/G pair type and the 4-bit group generate/propagate
// function used by both pipeline stages of pipelined_cla_adder.
package cla_pkg;

   localparam int CLA_GROUP_W = 4;

   typedef struct packed {
      logic gg;
      logic gp;
   } grp_pg_t;

   function automatic int num_groups(input int width);
      return width / CLA_GROUP_W;
   endfunction

   function automatic grp_pg_t group_pg(input logic [3:0] p, input logic [3:0] g);
      grp_pg_t r;
      r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.gp = &p;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result streaming bus of pipelined_cla_adder; ovf/zero exist only when
// CLA_ADDER_FLAGS_EN is defined.
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   Out;
`ifdef CLA_ADDER_FLAGS_EN
   logic             ovf;
   logic             zero;

   modport master (output in_valid, A, B, Cin, sub, out_ready,
                   input  in_ready, out_valid, Out, ovf, zero);
   modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                   output in_ready, out_valid, Out, ovf, zero);
`else
   modport master (output in_valid, A, B, Cin, sub, out_ready,
                   input  in_ready, out_valid, Out);
   modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                   output in_ready, out_valid, Out);
`endif
endinterface

// File: rtl/cla_group4.sv
// 4-bit combinational lookahead group: sum bits from a carry-in plus group
// generate/propagate.
module cla_group4
   import cla_pkg::*;
(
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       gg,
   output logic       gp
);
   logic [3:0] c;
   grp_pg_t    pg;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c;

   assign pg = group_pg(p, g);
   assign gg = pg.gg;
   assign gp = pg.gp;
endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_ADDER_FLAGS_EN to build the registered ovf/zero flags.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_cla_adder_if.slave bus
);
   localparam int NG = num_groups(WIDTH);

   generate
      if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
         $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
      end
   endgenerate

   // Flat sum-of-products carry into each group; index NG is the final carry out.
   function automatic logic [NG:0] group_carries(input logic [NG-1:0] gg,
                                                 input logic [NG-1:0] gp,
                                                 input logic          c0);
      logic [NG:0] c;
      logic        term;
      for (int k = 0; k <= NG; k++) begin
         term = c0;
         for (int m = 0; m < k; m++) term &= gp[m];
         c[k] = term;
         for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) term &= gp[m];
            c[k] |= term;
         end
      end
      return c;
   endfunction

   logic             s2_adv, s1_adv, accept;
   logic [WIDTH-1:0] b_eff, p_next, g_next;
   logic [NG-1:0]    gg_next, gp_next;
   logic             c0_next;

   logic             s1_valid_reg;
   logic [WIDTH-1:0] p_reg, g_reg;
   logic [NG-1:0]    gg_reg, gp_reg;
   logic             c0_reg;

   logic [NG:0]      grp_carry;
   logic [WIDTH-1:0] sum;
   logic [NG-1:0]    grp_gg_unused, grp_gp_unused;
   logic             out_valid_reg;
   logic [WIDTH:0]   out_reg;

   assign s2_adv      = !out_valid_reg || bus.out_ready;
   assign s1_adv      = !s1_valid_reg || s2_adv;
   assign bus.in_ready = !rst && s1_adv;
   assign accept      = bus.in_valid && bus.in_ready;

   assign b_eff   = bus.sub ? ~bus.B : bus.B;
   assign p_next  = bus.A ^ b_eff;
   assign g_next  = bus.A & b_eff;
   assign c0_next = bus.sub ? 1'b1 : bus.Cin;

   generate
      for (genvar gi = 0; gi < NG; gi++) begin : g_s1_grp
         grp_pg_t pg;
         assign pg          = group_pg(p_next[gi*4 +: 4], g_next[gi*4 +: 4]);
         assign gg_next[gi] = pg.gg;
         assign gp_next[gi] = pg.gp;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)         s1_valid_reg <= 1'b0;
      else if (s1_adv) s1_valid_reg <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         p_reg  <= p_next;
         g_reg  <= g_next;
         gg_reg <= gg_next;
         gp_reg <= gp_next;
         c0_reg <= c0_next;
      end
   end

   assign grp_carry = group_carries(gg_reg, gp_reg, c0_reg);

   // Group P/G are already registered from S1, so the S2 copies are left dangling.
   generate
      for (genvar gi = 0; gi < NG; gi++) begin : g_s2_grp
         cla_group4 u_grp (
            .p   (p_reg[gi*4 +: 4]),
            .g   (g_reg[gi*4 +: 4]),
            .cin (grp_carry[gi]),
            .sum (sum[gi*4 +: 4]),
            .gg  (grp_gg_unused[gi]),
            .gp  (grp_gp_unused[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_reg       <= '0;
      end else if (s2_adv) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) out_reg <= {grp_carry[NG], sum};
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.Out       = out_reg;

`ifdef CLA_ADDER_FLAGS_EN
   logic ovf_reg, zero_reg;

   // Carry into the MSB is recovered as P ^ sum at that bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else if (s2_adv && s1_valid_reg) begin
         ovf_reg  <= (p_reg[WIDTH-1] ^ sum[WIDTH-1]) ^ grp_carry[NG];
         zero_reg <= ~|sum;
      end
   end

   assign bus.ovf  = ovf_reg;
   assign bus.zero = zero_reg;
`endif

endmodule
